// File: rtl/bz2_pkg.sv
// Shared constants, state encoding and CRC fold helper for the bzip2 stream stages.
// No timing of its own; used by the trailer and block-header logic.
package bz2_pkg;

  localparam logic [47:0] BZ2_EOS_MAGIC = 48'h177245385090;
  localparam logic [47:0] BZ2_BLK_MAGIC = 48'h314159265359;
  localparam int          SR_W          = 88;

  typedef enum logic {IDLE, EMIT} state_t;

  // Trailer fields before left-alignment: only the low lead_bits of lead are meaningful.
  typedef struct packed {
    logic [6:0]  lead;
    logic [47:0] magic;
    logic [31:0] crc;
  } trailer_t;

  function automatic logic [31:0] bz2_fold_crc(input logic [31:0] comb, input logic [31:0] blk);
    return {comb[30:0], comb[31]} ^ blk;
  endfunction

endpackage

// File: rtl/trailer_shifter.sv
// Trailer byte shifter: one byte per accepted handshake, first byte valid the cycle after load.
// Byte and last flag hold while emit is high and out_ready is low.
module trailer_shifter
  import bz2_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SR_W-1:0] load_sr,
  input  logic [3:0]      load_cnt,
  input  logic            emit,
  input  logic            out_ready,
  output logic [7:0]      out_byte,
  output logic            out_last,
  output logic            done
);

  logic [SR_W-1:0] sr;
  logic [3:0]      remaining;
  logic            fire;

  assign fire = emit && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      remaining <= '0;
    end else if (load) begin
      sr        <= load_sr;
      remaining <= load_cnt;
    end else if (fire) begin
      sr        <= {sr[SR_W-9:0], 8'h00};
      remaining <= remaining - 4'd1;
    end
  end

  assign out_byte = emit ? sr[SR_W-1 -: 8] : 8'h00;
  assign out_last = emit && (remaining == 4'd1);
  assign done     = fire && (remaining == 4'd1);

endmodule

// File: rtl/bz2_stream_trailer.sv
// Folds block CRCs into the bzip2 stream CRC and emits the end-of-stream trailer bytes.
// First byte valid the cycle after finish; 1 byte/cycle under out_ready, holds while stalled.
module bz2_stream_trailer
  import bz2_pkg::*;
#(
  parameter int BLKCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stream_start,
  input  logic                block_done,
  input  logic [31:0]         block_crc,
  input  logic                finish,
  input  logic [2:0]          lead_bits,
  input  logic [6:0]          lead_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0]          out_byte,
  output logic                out_last,
  output logic                busy,
  output logic [31:0]         combined_crc,
  output logic [BLKCNT_W-1:0] block_count,
  output logic                err
);

  state_t              state, state_nxt;
  logic [31:0]         crc_base, crc_nxt;
  logic [BLKCNT_W-1:0] cnt_base, cnt_nxt;
  logic                err_nxt;
  logic                load;
  logic                done;
  logic [6:0]          lead_mask;
  trailer_t            fields;
  logic [SR_W-1:0]     sr_load;
  logic [3:0]          nbytes;

  // A same-cycle stream_start clears before the fold is applied.
  assign crc_base = stream_start ? 32'h0 : combined_crc;
  assign cnt_base = stream_start ? '0 : block_count;

  always_comb begin
    state_nxt = state;
    crc_nxt   = combined_crc;
    cnt_nxt   = block_count;
    err_nxt   = err;
    load      = 1'b0;
    case (state)
      IDLE: begin
        crc_nxt = crc_base;
        cnt_nxt = cnt_base;
        if (block_done) begin
          crc_nxt = bz2_fold_crc(crc_base, block_crc);
          if (cnt_base != {BLKCNT_W{1'b1}}) cnt_nxt = cnt_base + BLKCNT_W'(1);
        end
        if (finish) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (block_done || finish || stream_start) err_nxt = 1'b1;
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      combined_crc <= 32'h0;
      block_count  <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      combined_crc <= crc_nxt;
      block_count  <= cnt_nxt;
      err          <= err_nxt;
    end
  end

  // Shift left so the first lead bit (or the magic MSB when there is none) lands at bit 87.
  assign lead_mask    = 7'((8'd1 << lead_bits) - 8'd1);
  assign fields.lead  = lead_val & lead_mask;
  assign fields.magic = BZ2_EOS_MAGIC;
  assign fields.crc   = crc_nxt;
  assign sr_load      = SR_W'(fields) << (4'd8 - {1'b0, lead_bits});
  assign nbytes       = (lead_bits == 3'd0) ? 4'd10 : 4'd11;

  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);

  trailer_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_sr   (sr_load),
    .load_cnt  (nbytes),
    .emit      (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .done      (done)
  );

endmodule

// File: doc/bz2_stream_trailer.md
Name: bz2_stream_trailer

Overview:
- Downstream consumer of the per-block bzip2 CRC (inverted CRC32, MSB-first table form).
- Folds each finished block CRC into the bzip2 combined stream CRC.
- On end of stream, emits the stream trailer as a byte stream with valid/ready handshake:
  - optional leading partial bits from the bit packer;
  - 48-bit end-of-stream magic 0x177245385090;
  - 32-bit combined CRC;
  - zero pad to a byte boundary.
- Sits between the block CRC stage and the output byte mux.

Parameters:
- BLKCNT_W, 16, width of the block counter; saturates at all-ones.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- stream_start  in  1  pulse; clears combined CRC and block count for a new stream
- block_done  in  1  pulse; block_crc is valid this cycle
- block_crc  in  32  finished block CRC, already inverted
- finish  in  1  pulse; start emitting the trailer
- lead_bits  in  3  count of pending unflushed bits from the bit packer, 0..7; sampled on finish
- lead_val  in  7  pending bits, right-aligned; bit lead_bits-1 is sent first; sampled on finish
- out_valid  out  1  out_byte valid
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready
- out_byte  out  8  trailer byte
- out_last  out  1  marks the final trailer byte, qualified by out_valid
- busy  out  1  high from the cycle after an accepted finish until the last byte is accepted
- combined_crc  out  32  current combined stream CRC
- block_count  out  BLKCNT_W  blocks folded since stream_start
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - out_valid=0, out_last=0, out_byte=0, busy=0;
  - combined_crc=0, block_count=0, err=0;
  - state=IDLE.
- Reset takes effect mid-emission with no further bytes emitted.
- Combined CRC: on block_done in IDLE, combined_crc <= {combined_crc[30:0], combined_crc[31]} ^ block_crc, and block_count increments (saturating).
- Simultaneous events:
  - stream_start with block_done: clear first, then fold, so combined_crc=block_crc and block_count=1.
  - block_done with finish: fold first; the trailer carries the updated CRC.
  - stream_start with finish: the trailer carries CRC 0 and the block is folded as above.
- States:
  - IDLE: out_valid=0. On finish, load an 88-bit shift register left-aligned with {lead bits (lead_bits of them), magic[47:0], combined CRC after this cycle's fold, zeros}.
    - nbytes = 10 if lead_bits==0, else 11.
    - Go to EMIT.
  - EMIT: out_valid=1 and out_byte=sr[87:80].
    - out_last=1 when the remaining count is 1.
    - On handshake: sr <<= 8 and remaining decrements. After the last byte is accepted, go to IDLE.
    - out_byte, out_last and out_valid hold stable while out_ready=0.
- Latency: the first byte is valid the cycle after finish. With out_ready held high, throughput is 1 byte/cycle.
- busy equals (state==EMIT).
- Errors during EMIT, all setting err (sticky until rst):
  - block_done: ignored, no fold.
  - finish: ignored.
  - stream_start: ignored.
- combined_crc and block_count are unchanged by emission; only stream_start or rst clears them.
- Width rules:
  - lead_val bits at or above lead_bits are ignored.
  - All CRC arithmetic is modulo 2^32 as bit ops; no carries.

Decomposition:
- Package bz2_pkg holds:
  - BZ2_EOS_MAGIC (48'h177245385090);
  - BZ2_BLK_MAGIC (48'h314159265359) for the block-header stage;
  - the state enum typedef {IDLE, EMIT};
  - a function bz2_fold_crc(comb, blk) implementing rotate-xor.
- Sub-module trailer_shifter: load, shift on handshake, remaining count, out_last generation. The top holds the CRC accumulator and control.

Test Plan:
- Empty stream, byte-aligned: rst, stream_start, finish with lead_bits=0 and out_ready=1.
  - Required bytes: 17 72 45 38 50 90 00 00 00 00.
  - out_last only on the 10th byte; busy high for 10 cycles.
- Combined CRC: block_done with 0x80000001, then block_done with 0x00000000.
  - combined_crc=0x80000001, then 0x00000003; block_count=2.
  - finish then emits ... 90 00 00 00 03.
- Unaligned lead: a single block with block_crc=0, then finish with lead_bits=4, lead_val=7'b0001010.
  - Required 11 bytes: A1 77 24 53 85 09 00 00 00 00 00.
- Backpressure: toggle out_ready randomly during the empty-stream trailer.
  - Same 10-byte sequence; out_byte and out_last stable while stalled; no duplicate or dropped bytes.
- Simultaneous and error events:
  - block_done(0x12345678) in the same cycle as finish: trailer CRC field reads 12 34 56 78.
  - block_done during EMIT: err=1 and combined_crc unchanged.
- Reset mid-emission: assert rst after the 3rd byte.
  - Next cycle: out_valid=0, busy=0, combined_crc=0, err=0.
  - A subsequent finish emits the full 10-byte empty-stream trailer.
